// File: rtl/register_file_if.sv
// Register-file port bundle: two read selects/data and one write port.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] ReadRegister1;
  logic [ADDR_WIDTH-1:0] ReadRegister2;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RegWrite;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;

  // datapath side: drives selects and write port, consumes read data
  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
    input  ReadData1, ReadData2
  );

  // register file side
  modport slave (
    input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/register_file.sv
// MIPS-style register file: NUM_REGS x DATA_WIDTH, r0 hardwired to zero,
// two combinational read ports, one synchronous write port, no bypass.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic            Clk,
  input  logic            Reset_n,
  register_file_if.slave  rf
);

  // r0 has no storage; only registers 1..NUM_REGS-1 are flops
  logic [NUM_REGS-1:1][DATA_WIDTH-1:0] regs_q, regs_d;
  // full read view with r0 tied to zero in the bottom slot
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rd_view;

  // per-register decoded write enable; unselected registers hold
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rf.RegWrite && (rf.WriteRegister == ADDR_WIDTH'(i)))
        regs_d[i] = rf.WriteData;
    end
  end

  // storage; async reset clears the whole array and blocks writes
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) regs_q <= '0;
    else          regs_q <= regs_d;
  end

  assign rd_view = {regs_q, {DATA_WIDTH{1'b0}}};

  // two full-width read muxes; reads see the array before any same-cycle write
  always_comb begin
    rf.ReadData1 = rd_view[rf.ReadRegister1];
    rf.ReadData2 = rd_view[rf.ReadRegister2];
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
  logic Clk;
  logic Reset_n;
  int   checks;
  int   errors;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_if ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .rf      (rf_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    rf_if.ReadRegister1 = a1;
    rf_if.ReadRegister2 = a2;
    #1;
  endtask

  // drive a write at the falling edge, let it land at the next rising edge
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic en);
    @(negedge Clk);
    rf_if.WriteRegister = a;
    rf_if.WriteData     = d;
    rf_if.RegWrite      = en;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset_n = 1'b0;
    rf_if.ReadRegister1 = '0;
    rf_if.ReadRegister2 = '0;
    rf_if.WriteRegister = '0;
    rf_if.WriteData     = '0;
    rf_if.RegWrite      = 1'b0;

    // reset held two cycles, every address reads zero
    repeat (2) @(posedge Clk);
    #1;
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      chk($sformatf("rst_rd1_%0d", a), rf_if.ReadData1, 32'h0);
      chk($sformatf("rst_rd2_%0d", 31 - a), rf_if.ReadData2, 32'h0);
    end

    @(negedge Clk);
    Reset_n = 1'b1;

    // fill regs 8..25 with 0x100+n
    for (int n = 8; n <= 25; n++) wr(5'(n), 32'h100 + 32'(n), 1'b1);
    @(negedge Clk);
    rf_if.RegWrite = 1'b0;
    for (int n = 8; n <= 24; n += 2) begin
      rd(5'(n), 5'(n + 1));
      chk($sformatf("fill_rd1_%0d", n), rf_if.ReadData1, 32'h100 + 32'(n));
      chk($sformatf("fill_rd2_%0d", n + 1), rf_if.ReadData2, 32'h100 + 32'(n + 1));
    end
    rd(5'd7, 5'd26);
    chk("fill_untouched7", rf_if.ReadData1, 32'h0);
    chk("fill_untouched26", rf_if.ReadData2, 32'h0);

    // writes to r0 are discarded
    wr(5'd0, 32'hDEADBEEF, 1'b1);
    rd(5'd0, 5'd0);
    chk("r0_rd1", rf_if.ReadData1, 32'h0);
    chk("r0_rd2", rf_if.ReadData2, 32'h0);

    // RegWrite low leaves reg 12 alone across 3 edges
    @(negedge Clk);
    rf_if.WriteRegister = 5'd12;
    rf_if.WriteData     = 32'hFFFFFFFF;
    rf_if.RegWrite      = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    rd(5'd12, 5'd12);
    chk("gate_r12", rf_if.ReadData1, 32'h0000010C);

    // read-during-write: old value before the edge, new value after
    @(negedge Clk);
    rd(5'd15, 5'd15);
    rf_if.WriteRegister = 5'd15;
    rf_if.WriteData     = 32'hCAFEF00D;
    rf_if.RegWrite      = 1'b1;
    #1;
    chk("rdw_pre_rd1", rf_if.ReadData1, 32'h0000010F);
    chk("rdw_pre_rd2", rf_if.ReadData2, 32'h0000010F);
    @(posedge Clk);
    #1;
    chk("rdw_post_rd1", rf_if.ReadData1, 32'hCAFEF00D);
    chk("rdw_post_rd2", rf_if.ReadData2, 32'hCAFEF00D);
    @(negedge Clk);
    rf_if.RegWrite = 1'b0;
    rd(5'd14, 5'd16);
    chk("rdw_nbr14", rf_if.ReadData1, 32'h0000010E);
    chk("rdw_nbr16", rf_if.ReadData2, 32'h00000110);

    // write reg 31 (top boundary), then async reset mid-cycle
    wr(5'd31, 32'h13579BDF, 1'b1);
    rd(5'd31, 5'd20);
    chk("top_r31", rf_if.ReadData1, 32'h13579BDF);
    chk("pre_rst_r20", rf_if.ReadData2, 32'h00000114);
    rf_if.WriteRegister = 5'd20;
    rf_if.WriteData     = 32'hA5A5A5A5;
    rf_if.RegWrite      = 1'b1;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_r31", rf_if.ReadData1, 32'h0);
    chk("arst_r20", rf_if.ReadData2, 32'h0);
    // write attempt while in reset is blocked
    @(posedge Clk);
    #1;
    chk("arst_blk_r20", rf_if.ReadData2, 32'h0);
    @(negedge Clk);
    rf_if.RegWrite = 1'b0;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    rd(5'd8, 5'd20);
    chk("post_rst_r8", rf_if.ReadData1, 32'h0);
    chk("post_rst_r20", rf_if.ReadData2, 32'h0);

    // new writes work again after reset
    wr(5'd1, 32'h0BADF00D, 1'b1);
    @(negedge Clk);
    rf_if.RegWrite = 1'b0;
    rd(5'd1, 5'd2);
    chk("post_rst_w_r1", rf_if.ReadData1, 32'h0BADF00D);
    chk("post_rst_w_r2", rf_if.ReadData2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- MIPS-style general-purpose register file: 32 registers of 32 bits each, two combinational read ports and one synchronous write port.
- Sits in the decode stage of the datapath.
- Register 0 always reads as zero.
- Feeds ALU operands and store data; the write port is driven by the write-back stage.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the register-select ports.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_WIDTH.

Ports:
- Clk  input  1  system clock; all writes occur on its rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- ReadRegister1  input  ADDR_WIDTH  select for read port 1.
- ReadRegister2  input  ADDR_WIDTH  select for read port 2.
- WriteRegister  input  ADDR_WIDTH  select for the write port.
- WriteData  input  DATA_WIDTH  value to write.
- RegWrite  input  1  write enable, active high.
- ReadData1  output  DATA_WIDTH  contents of register ReadRegister1.
- ReadData2  output  DATA_WIDTH  contents of register ReadRegister2.

Behaviour:
- The design has one clock, Clk. Reset is asynchronous and active-low (Reset_n).
- Reset:
  - Reset_n low clears all registers to 0 immediately, independent of Clk.
  - While Reset_n is low, ReadData1 and ReadData2 read 0 and writes are blocked.
  - Deassertion takes effect at the next rising Clk edge.
- Write:
  - At a rising Clk edge with Reset_n high and RegWrite=1, the register at WriteRegister is loaded with WriteData.
  - RegWrite=0 leaves all registers unchanged.
  - Latency: the written value is visible on the read ports immediately after that edge; write-to-read latency is 0 cycles after the edge.
- Register 0:
  - Writes to register 0 are discarded.
  - A read of address 0 always returns 0, including directly after an attempted write to it.
- Read:
  - Purely combinational.
  - ReadDataN reflects the current array contents for ReadRegisterN with no clock dependence.
  - Both ports may select the same register; both then return identical data.
- No internal write-to-read bypass:
  - In the cycle where WriteRegister equals a ReadRegister and RegWrite=1, the read port shows the old value until the rising edge, then the new value.
  - Hazard resolution is handled externally by the datapath.
- Simultaneous events:
  - A reset edge coincident with a clock edge: reset wins and the array is 0.
  - Reset assertion in the middle of a cycle clears any value written earlier in that cycle.
- There are no X or undefined outputs after reset: all addresses are in range because of the ADDR_WIDTH and NUM_REGS relationship.
- Intended implementation:
  - Array of NUM_REGS-1 flops for registers 1..NUM_REGS-1, with a per-register decoded write enable.
  - Two NUM_REGS:1 read multiplexers.

Test Plan:
- Reset: hold Reset_n=0 for 2 cycles, sweep ReadRegister1/2 over 0..31 -> every read returns 0x00000000.
- Fill and read back:
  - Stimulus: write registers 8..25 with value 0x100+n (e.g. reg 8 = 0x00000108, reg 25 = 0x00000119), one per cycle, RegWrite=1. Then read them in pairs (8,9), (10,11) … (24,25).
  - Response: each port returns the matching 0x100+n.
- Register zero: write 0xDEADBEEF to register 0 with RegWrite=1, then read port 1 = 0 and port 2 = 0 -> both return 0x00000000.
- Write enable gating: reg 12 holds 0x0000010C; present WriteRegister=12, WriteData=0xFFFFFFFF, RegWrite=0 for 3 edges -> reg 12 still reads 0x0000010C.
- Read-during-write:
  - Stimulus: ReadRegister1=ReadRegister2=15 (holding 0x0000010F), WriteData=0xCAFEF00D, RegWrite=1.
  - Response: both ports show 0x0000010F before the edge and 0xCAFEF00D after it.
- Asynchronous reset mid-operation: registers loaded, pull Reset_n low midway between clock edges -> reads drop to 0 before the next edge, and stay 0 after Reset_n is released until new writes occur.
